// File: rtl/mmio_calc_responder.sv
// Memory-mapped operand/operator/result register block shared by the FPGA front end
// and the CPU load/store port; one access in flight at a time, CPU has priority.
module mmio_calc_responder #(
    parameter logic [31:0] ADDR_OP1    = 32'd220,
    parameter logic [31:0] ADDR_OP2    = 32'd240,
    parameter logic [31:0] ADDR_OPSEL  = 32'd260,
    parameter logic [31:0] ADDR_RESULT = 32'd280,
    parameter logic [31:0] ADDR_IDLE   = 32'd320
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fpga_en,
    input  logic        fpga_write,
    input  logic [31:0] fpga_addr,
    input  logic [31:0] fpga_wdata,
    output logic [31:0] fpga_rdata,
    output logic        fpga_ack,
    input  logic        cpu_en,
    input  logic        cpu_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        ops_ready,
    output logic        result_valid
);

    typedef enum logic [1:0] {StIdle, StFpgaAcc, StCpuAcc, StResp} state_e;

    state_e      state_q, state_d;
    logic        req_write_q, req_write_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] req_wdata_q, req_wdata_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic [31:0] opsel_q, opsel_d;
    logic [31:0] result_q, result_d;
    logic        v_op1_q, v_op1_d;
    logic        v_op2_q, v_op2_d;
    logic        v_opsel_q, v_opsel_d;
    logic        result_valid_q, result_valid_d;
    logic        ops_ready_q, ops_ready_d;
    logic [31:0] fpga_rdata_q, fpga_rdata_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic        fpga_ack_q, fpga_ack_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic [31:0] rd_mux;

    // ADDR_IDLE and unmapped addresses read as zero on both ports.
    always_comb begin
        rd_mux = 32'd0;
        if (req_addr_q == ADDR_OP1)         rd_mux = op1_q;
        else if (req_addr_q == ADDR_OP2)    rd_mux = op2_q;
        else if (req_addr_q == ADDR_OPSEL)  rd_mux = opsel_q;
        else if (req_addr_q == ADDR_RESULT) rd_mux = result_q;
    end

    always_comb begin
        state_d        = state_q;
        req_write_d    = req_write_q;
        req_addr_d     = req_addr_q;
        req_wdata_d    = req_wdata_q;
        op1_d          = op1_q;
        op2_d          = op2_q;
        opsel_d        = opsel_q;
        result_d       = result_q;
        v_op1_d        = v_op1_q;
        v_op2_d        = v_op2_q;
        v_opsel_d      = v_opsel_q;
        result_valid_d = result_valid_q;
        fpga_rdata_d   = fpga_rdata_q;
        cpu_rdata_d    = cpu_rdata_q;
        fpga_ack_d     = 1'b0;
        cpu_ack_d      = 1'b0;
        ops_ready_d    = v_op1_q & v_op2_q & v_opsel_q & ~result_valid_q;

        unique case (state_q)
            StIdle: begin
                if (cpu_en) begin
                    state_d     = StCpuAcc;
                    req_write_d = cpu_write;
                    req_addr_d  = cpu_addr;
                    req_wdata_d = cpu_wdata;
                end else if (fpga_en) begin
                    state_d     = StFpgaAcc;
                    req_write_d = fpga_write;
                    req_addr_d  = fpga_addr;
                    req_wdata_d = fpga_wdata;
                end
            end
            StFpgaAcc: begin
                state_d    = StResp;
                fpga_ack_d = 1'b1;
                if (req_write_q) begin
                    if (req_addr_q == ADDR_OP1) begin
                        op1_d          = req_wdata_q;
                        v_op1_d        = 1'b1;
                        result_valid_d = 1'b0;
                    end else if (req_addr_q == ADDR_OP2) begin
                        op2_d          = req_wdata_q;
                        v_op2_d        = 1'b1;
                        result_valid_d = 1'b0;
                    end else if (req_addr_q == ADDR_OPSEL) begin
                        opsel_d        = {24'd0, req_wdata_q[7:0]};
                        v_opsel_d      = 1'b1;
                        result_valid_d = 1'b0;
                    end
                end else begin
                    fpga_rdata_d = rd_mux;
                    // Reading the result consumes the whole operation.
                    if (req_addr_q == ADDR_RESULT) begin
                        v_op1_d        = 1'b0;
                        v_op2_d        = 1'b0;
                        v_opsel_d      = 1'b0;
                        result_valid_d = 1'b0;
                    end
                end
            end
            StCpuAcc: begin
                state_d   = StResp;
                cpu_ack_d = 1'b1;
                if (req_write_q) begin
                    if (req_addr_q == ADDR_RESULT) begin
                        result_d       = req_wdata_q;
                        result_valid_d = 1'b1;
                    end
                end else begin
                    cpu_rdata_d = rd_mux;
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            req_write_q    <= 1'b0;
            req_addr_q     <= 32'd0;
            req_wdata_q    <= 32'd0;
            op1_q          <= 32'd0;
            op2_q          <= 32'd0;
            opsel_q        <= 32'd0;
            result_q       <= 32'd0;
            v_op1_q        <= 1'b0;
            v_op2_q        <= 1'b0;
            v_opsel_q      <= 1'b0;
            result_valid_q <= 1'b0;
            ops_ready_q    <= 1'b0;
            fpga_rdata_q   <= 32'd0;
            cpu_rdata_q    <= 32'd0;
            fpga_ack_q     <= 1'b0;
            cpu_ack_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            req_write_q    <= req_write_d;
            req_addr_q     <= req_addr_d;
            req_wdata_q    <= req_wdata_d;
            op1_q          <= op1_d;
            op2_q          <= op2_d;
            opsel_q        <= opsel_d;
            result_q       <= result_d;
            v_op1_q        <= v_op1_d;
            v_op2_q        <= v_op2_d;
            v_opsel_q      <= v_opsel_d;
            result_valid_q <= result_valid_d;
            ops_ready_q    <= ops_ready_d;
            fpga_rdata_q   <= fpga_rdata_d;
            cpu_rdata_q    <= cpu_rdata_d;
            fpga_ack_q     <= fpga_ack_d;
            cpu_ack_q      <= cpu_ack_d;
        end
    end

    assign fpga_rdata   = fpga_rdata_q;
    assign fpga_ack     = fpga_ack_q;
    assign cpu_rdata    = cpu_rdata_q;
    assign cpu_ack      = cpu_ack_q;
    assign ops_ready    = ops_ready_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_mmio_calc_responder.sv
// Directed bench for mmio_calc_responder: hand-computed expectations checked with
// immediate assertions, outputs sampled on the falling edge.
module tb_mmio_calc_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fpga_en = 1'b0, fpga_write = 1'b0;
    logic [31:0] fpga_addr = 32'd0, fpga_wdata = 32'd0;
    logic [31:0] fpga_rdata;
    logic        fpga_ack;
    logic        cpu_en = 1'b0, cpu_write = 1'b0;
    logic [31:0] cpu_addr = 32'd0, cpu_wdata = 32'd0;
    logic [31:0] cpu_rdata;
    logic        cpu_ack;
    logic        ops_ready;
    logic        result_valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mmio_calc_responder dut (
        .clk          (clk),
        .rst          (rst),
        .fpga_en      (fpga_en),
        .fpga_write   (fpga_write),
        .fpga_addr    (fpga_addr),
        .fpga_wdata   (fpga_wdata),
        .fpga_rdata   (fpga_rdata),
        .fpga_ack     (fpga_ack),
        .cpu_en       (cpu_en),
        .cpu_write    (cpu_write),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_ack      (cpu_ack),
        .ops_ready    (ops_ready),
        .result_valid (result_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access; returns at the falling edge of the cycle in which ack is expected high.
    task automatic xfer(input bit is_cpu, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input bit chk, input logic [31:0] exp,
                        input string tag);
        @(negedge clk);
        if (is_cpu) begin
            cpu_en = 1'b1; cpu_write = wr; cpu_addr = a; cpu_wdata = d;
        end else begin
            fpga_en = 1'b1; fpga_write = wr; fpga_addr = a; fpga_wdata = d;
        end
        @(posedge clk);
        #1;
        cpu_en  = 1'b0;
        fpga_en = 1'b0;
        @(negedge clk);
        check({tag, "_ack_early"}, {31'd0, is_cpu ? cpu_ack : fpga_ack}, 32'd0);
        @(negedge clk);
        check({tag, "_ack"}, {31'd0, is_cpu ? cpu_ack : fpga_ack}, 32'd1);
        if (chk) check({tag, "_rdata"}, is_cpu ? cpu_rdata : fpga_rdata, exp);
    endtask

    initial begin
        int gap;
        bit seen;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_fpga_ack", {31'd0, fpga_ack}, 32'd0);
        check("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
        check("rst_ops_ready", {31'd0, ops_ready}, 32'd0);
        check("rst_result_valid", {31'd0, result_valid}, 32'd0);
        check("rst_fpga_rdata", fpga_rdata, 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);

        // Operand entry from the front end.
        xfer(1'b0, 1'b1, 32'd220, 32'h12, 1'b0, 32'd0, "wr_op1");
        xfer(1'b0, 1'b1, 32'd260, 32'h10A, 1'b0, 32'd0, "wr_opsel");
        @(negedge clk);
        check("ops_ready_partial", {31'd0, ops_ready}, 32'd0);
        xfer(1'b0, 1'b1, 32'd240, 32'h34, 1'b0, 32'd0, "wr_op2");
        check("ops_ready_same_cycle", {31'd0, ops_ready}, 32'd0);
        check("rv_after_ops", {31'd0, result_valid}, 32'd0);
        @(negedge clk);
        check("ops_ready_set", {31'd0, ops_ready}, 32'd1);

        // CPU picks up the operands (opsel keeps only the low byte) and posts a result.
        xfer(1'b1, 1'b0, 32'd220, 32'd0, 1'b1, 32'h12, "cpu_rd_op1");
        xfer(1'b1, 1'b0, 32'd240, 32'd0, 1'b1, 32'h34, "cpu_rd_op2");
        xfer(1'b1, 1'b0, 32'd260, 32'd0, 1'b1, 32'h0A, "cpu_rd_opsel");
        check("ops_ready_after_reads", {31'd0, ops_ready}, 32'd1);
        xfer(1'b1, 1'b1, 32'd280, 32'h46, 1'b0, 32'd0, "cpu_wr_res");
        check("rv_set", {31'd0, result_valid}, 32'd1);
        @(negedge clk);
        check("ops_ready_clr_by_res", {31'd0, ops_ready}, 32'd0);

        // Front end consumes the result.
        xfer(1'b0, 1'b0, 32'd280, 32'd0, 1'b1, 32'h46, "fpga_rd_res");
        @(negedge clk);
        check("rv_clr", {31'd0, result_valid}, 32'd0);
        check("ops_ready_after_consume", {31'd0, ops_ready}, 32'd0);
        xfer(1'b1, 1'b0, 32'd280, 32'd0, 1'b1, 32'h46, "res_kept");

        // Simultaneous requests: CPU first, FPGA three cycles later.
        @(negedge clk);
        cpu_en = 1'b1; cpu_write = 1'b0; cpu_addr = 32'd220;
        fpga_en = 1'b1; fpga_write = 1'b1; fpga_addr = 32'd220; fpga_wdata = 32'h99;
        @(posedge clk);
        #1 cpu_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("sim_cpu_ack", {31'd0, cpu_ack}, 32'd1);
        check("sim_cpu_rdata", cpu_rdata, 32'h12);
        check("sim_fpga_ack_not_yet", {31'd0, fpga_ack}, 32'd0);
        gap = 0;
        seen = 1'b0;
        for (int i = 1; i <= 10 && !seen; i++) begin
            @(negedge clk);
            if (fpga_ack) begin
                seen = 1'b1;
                gap = i;
            end
        end
        fpga_en = 1'b0;
        check("sim_fpga_ack_gap", gap, 32'd3);
        xfer(1'b1, 1'b0, 32'd220, 32'd0, 1'b1, 32'h99, "sim_op1_new");
        // Only op1 is valid again after the clear-on-read.
        check("ops_ready_flags_cleared", {31'd0, ops_ready}, 32'd0);

        // CPU cannot overwrite operands; unmapped FPGA read returns zero.
        xfer(1'b1, 1'b1, 32'd220, 32'hDEAD, 1'b0, 32'd0, "cpu_wr_op1");
        xfer(1'b0, 1'b0, 32'h500, 32'd0, 1'b1, 32'd0, "fpga_rd_unmapped");
        xfer(1'b1, 1'b0, 32'd220, 32'd0, 1'b1, 32'h99, "op1_protected");

        // Reset during FPGA_ACC discards the write and suppresses the ack.
        @(negedge clk);
        fpga_en = 1'b1; fpga_write = 1'b1; fpga_addr = 32'd240; fpga_wdata = 32'h77;
        @(posedge clk);
        #1 fpga_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ack", {31'd0, fpga_ack}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_ack2", {31'd0, fpga_ack}, 32'd0);
        xfer(1'b1, 1'b0, 32'd240, 32'd0, 1'b1, 32'd0, "rst_mid_op2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
